// File: rtl/rx_sample_reader.sv
// rx_sample_reader: steps the RX readout mux through I, Q and packed words per sample
// and stores them in a first-word-fall-through FIFO. Define RX_READER_TSTAMP_EN to add a sequence word.
module rx_sample_reader #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  adc_clk,
    input  logic                  reset,
    input  logic                  rx_avail,
    input  logic [15:0]           rx_din,
    output logic                  rd_i,
    output logic                  rd_q,
    input  logic                  pop,
    output logic [15:0]           dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovfl,
    input  logic                  clr_ovfl,
    output logic [15:0]           drop_cnt
);

    localparam int DATA_W = 16;
    localparam int PTR_W  = DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
`ifdef RX_READER_TSTAMP_EN
    localparam int WORDS  = 4;
`else
    localparam int WORDS  = 3;
`endif
    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] WORDS_V = CNT_W'(WORDS);

`ifdef RX_READER_TSTAMP_EN
    typedef enum logic [2:0] {IDLE, RD_I, RD_Q, RD_X, RD_T} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD_I, RD_Q, RD_X} state_t;
`endif

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + DATA_W'(1);
    endfunction

    state_t             state;
    state_t             next_state;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   free_slots;
    logic               has_space;
    logic               push;
    logic [DATA_W-1:0]  push_data;
    logic               do_pop;
    logic               drop;

`ifdef RX_READER_TSTAMP_EN
    logic [DATA_W-1:0]  sample_cnt;
`endif

    // Space is checked for the whole sample up front so a sample is never split.
    assign free_slots = DEPTH_V - count;
    assign has_space  = (free_slots >= WORDS_V);
    assign drop       = rx_avail && !((state == IDLE) && has_space);
    assign empty      = (count == '0);
    assign do_pop     = pop && !empty;
    assign dout       = empty ? '0 : mem[rd_ptr];

    always_comb begin
        next_state = state;
        push       = 1'b0;
        push_data  = rx_din;
        case (state)
            IDLE: begin
                if (rx_avail && has_space) begin
                    next_state = RD_I;
                end
            end
            RD_I: begin
                push       = 1'b1;
                next_state = RD_Q;
            end
            RD_Q: begin
                push       = 1'b1;
                next_state = RD_X;
            end
            RD_X: begin
                push       = 1'b1;
`ifdef RX_READER_TSTAMP_EN
                next_state = RD_T;
`else
                next_state = IDLE;
`endif
            end
`ifdef RX_READER_TSTAMP_EN
            RD_T: begin
                push       = 1'b1;
                push_data  = sample_cnt;
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Selects are registered from next_state so they line up with the state that pushes.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state <= IDLE;
            rd_i  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            state <= next_state;
            rd_i  <= (next_state == RD_I);
            rd_q  <= (next_state == RD_Q);
        end
    end

    always_ff @(posedge adc_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins: the clear still zeroes the old tally.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            ovfl     <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovfl     <= 1'b1;
            drop_cnt <= clr_ovfl ? DATA_W'(1) : sat_inc(drop_cnt);
        end else if (clr_ovfl) begin
            ovfl     <= 1'b0;
            drop_cnt <= '0;
        end
    end

`ifdef RX_READER_TSTAMP_EN
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (state == RD_T) begin
            sample_cnt <= sample_cnt + DATA_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rx_sample_reader.sv
// Scoreboard bench for rx_sample_reader (DEPTH_LOG2=3); expected words queued at each strobe.
module tb_rx_sample_reader;

    localparam int DL2   = 3;
    localparam int DEPTH = 1 << DL2;
    localparam int CW    = DL2 + 1;
`ifdef RX_READER_TSTAMP_EN
    localparam int W = 4;
`else
    localparam int W = 3;
`endif
    localparam int REFILL_POPS = W - (DEPTH - 2 * W);

    logic          adc_clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_avail = 1'b0;
    logic          pop = 1'b0;
    logic          clr_ovfl = 1'b0;
    logic          rd_i, rd_q, empty, ovfl;
    logic [15:0]   rx_din, dout, drop_cnt;
    logic [CW-1:0] count;
    logic [15:0]   cur_i = 16'h0;
    logic [15:0]   cur_q = 16'h0;

    int            checks = 0;
    int            failures = 0;
    logic [15:0]   exp_q[$];
    bit            pop_en = 1'b0;
    int            pop_budget = 0;
`ifdef RX_READER_TSTAMP_EN
    logic [15:0]   ts_exp = 16'h0;
`endif

    rx_sample_reader #(.DEPTH_LOG2(DL2)) dut (
        .adc_clk  (adc_clk),
        .reset    (reset),
        .rx_avail (rx_avail),
        .rx_din   (rx_din),
        .rd_i     (rd_i),
        .rd_q     (rd_q),
        .pop      (pop),
        .dout     (dout),
        .empty    (empty),
        .count    (count),
        .ovfl     (ovfl),
        .clr_ovfl (clr_ovfl),
        .drop_cnt (drop_cnt)
    );

    // RX chain readout mux model
    assign rx_din = rd_i ? cur_i : (rd_q ? cur_q : {cur_i[15:8], cur_q[15:8]});

    always #5 adc_clk = ~adc_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n cycles; acts as the consumer, popping and scoring head words.
    task automatic tick(input int n);
        logic [15:0] exp_w;
        for (int k = 0; k < n; k++) begin
            @(negedge adc_clk);
            if ((pop_en || pop_budget > 0) && !empty) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL fifo_word: got %h, scoreboard empty", dout);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (dout !== exp_w) begin
                        failures++;
                        $display("FAIL fifo_word: got %h expected %h", dout, exp_w);
                    end
                end
                pop = 1'b1;
                if (pop_budget > 0) pop_budget--;
            end else begin
                pop = pop_en;
            end
        end
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q, input bit acc);
        cur_i    = i;
        cur_q    = q;
        rx_avail = 1'b1;
        if (acc) begin
            exp_q.push_back(i);
            exp_q.push_back(q);
            exp_q.push_back({i[15:8], q[15:8]});
`ifdef RX_READER_TSTAMP_EN
            exp_q.push_back(ts_exp);
            ts_exp = ts_exp + 16'd1;
`endif
        end
        tick(1);
        rx_avail = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        rx_avail   = 1'b0;
        clr_ovfl   = 1'b0;
        pop_en     = 1'b0;
        pop_budget = 0;
        tick(3);
        reset = 1'b0;
        exp_q.delete();
`ifdef RX_READER_TSTAMP_EN
        ts_exp = 16'h0;
`endif
        tick(1);
    endtask

    task automatic drain();
        pop_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && empty) break;
            tick(1);
        end
        checks++;
        if (!(exp_q.size() == 0 && empty)) begin
            failures++;
            $display("FAIL drain: left %0d words empty=%b, required 0 words empty=1", exp_q.size(), empty);
        end
        tick(3);
        checks++;
        if ({empty, count} !== {1'b1, CW'(0)}) begin
            failures++;
            $display("FAIL pop_while_empty: empty=%b count=%0d, required empty=1 count=0", empty, count);
        end
        pop_en = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rd_i, rd_q, empty, count, ovfl, drop_cnt, dout} !== {1'b0, 1'b0, 1'b1, CW'(0), 1'b0, 16'h0, 16'h0}) begin
            failures++;
            $display("FAIL reset_state: rd_i=%b rd_q=%b empty=%b count=%0d ovfl=%b drop=%0d dout=%h, required 0 0 1 0 0 0 0000",
                     rd_i, rd_q, empty, count, ovfl, drop_cnt, dout);
        end
    endtask

    task automatic test_basic();
        send(16'h1234, 16'hABCD, 1'b1);
        checks++;
        if ({rd_i, rd_q} !== 2'b10) begin
            failures++;
            $display("FAIL sel_n1: rd_i,rd_q=%b%b, required 10", rd_i, rd_q);
        end
        tick(1);
        checks++;
        if ({rd_i, rd_q, empty, dout} !== {2'b01, 1'b0, 16'h1234}) begin
            failures++;
            $display("FAIL first_word_n2: rd=%b%b empty=%b dout=%h, required rd=01 empty=0 dout=1234", rd_i, rd_q, empty, dout);
        end
        tick(1);
        checks++;
        if ({rd_i, rd_q, count} !== {2'b00, CW'(2)}) begin
            failures++;
            $display("FAIL sel_n3: rd=%b%b count=%0d, required rd=00 count=2", rd_i, rd_q, count);
        end
        tick(1);
        checks++;
        if (count !== CW'(3)) begin
            failures++;
            $display("FAIL count_n4: got %0d, required 3", count);
        end
`ifdef RX_READER_TSTAMP_EN
        tick(1);
        checks++;
        if (count !== CW'(4)) begin
            failures++;
            $display("FAIL count_n5: got %0d, required 4", count);
        end
`endif
        drain();
        checks++;
        if (ovfl !== 1'b0) begin
            failures++;
            $display("FAIL basic_ovfl: got %b, required 0", ovfl);
        end
    endtask

    task automatic test_overflow();
        send(16'h1111, 16'h2222, 1'b1);
        tick(W + 1);
        send(16'h3333, 16'h4444, 1'b1);
        tick(W + 1);
        checks++;
        if (count !== CW'(2 * W)) begin
            failures++;
            $display("FAIL fill_count: got %0d, required %0d", count, 2 * W);
        end
        send(16'h5555, 16'h6666, 1'b0);
        tick(W + 1);
        checks++;
        if ({count, ovfl, drop_cnt} !== {CW'(2 * W), 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL first_drop: count=%0d ovfl=%b drop=%0d, required %0d 1 1", count, ovfl, drop_cnt, 2 * W);
        end
        pop_budget = REFILL_POPS;
        tick(REFILL_POPS + 3);
        checks++;
        if (count !== CW'(DEPTH - W)) begin
            failures++;
            $display("FAIL after_pops: count=%0d, required %0d", count, DEPTH - W);
        end
        send(16'h7777, 16'h8888, 1'b1);
        tick(W + 1);
        checks++;
        if (count !== CW'(DEPTH)) begin
            failures++;
            $display("FAIL exact_fit: count=%0d, required %0d", count, DEPTH);
        end
        send(16'h9999, 16'hAAAA, 1'b0);
        tick(W + 1);
        checks++;
        if ({count, ovfl, drop_cnt} !== {CW'(DEPTH), 1'b1, 16'd2}) begin
            failures++;
            $display("FAIL full_drop: count=%0d ovfl=%b drop=%0d, required %0d 1 2", count, ovfl, drop_cnt, DEPTH);
        end
        clr_ovfl = 1'b1;
        tick(1);
        clr_ovfl = 1'b0;
        checks++;
        if ({ovfl, drop_cnt} !== {1'b0, 16'd0}) begin
            failures++;
            $display("FAIL clear: ovfl=%b drop=%0d, required 0 0", ovfl, drop_cnt);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        send(16'hC0DE, 16'hBEEF, 1'b1);
        send(16'hC0DE, 16'hBEEF, 1'b0);
        tick(1);
        send(16'hC0DE, 16'hBEEF, 1'b0);
        tick(W + 1);
        checks++;
        if ({ovfl, drop_cnt} !== {1'b1, 16'd2}) begin
            failures++;
            $display("FAIL busy_drop: ovfl=%b drop=%0d, required 1 2", ovfl, drop_cnt);
        end
        drain();
    endtask

    task automatic test_clr_priority();
        send(16'h0F0F, 16'hF0F0, 1'b1);
        rx_avail = 1'b1;
        clr_ovfl = 1'b1;
        tick(1);
        rx_avail = 1'b0;
        clr_ovfl = 1'b0;
        checks++;
        if ({ovfl, drop_cnt} !== {1'b1, 16'd1}) begin
            failures++;
            $display("FAIL clr_vs_drop: ovfl=%b drop=%0d, required 1 1", ovfl, drop_cnt);
        end
        tick(W);
        drain();
    endtask

    task automatic test_wrap();
        clr_ovfl = 1'b1;
        tick(1);
        clr_ovfl = 1'b0;
        pop_en = 1'b1;
        for (int k = 0; k < DEPTH + 5; k++) begin
            send(16'h1000 + 16'(k), 16'hF000 - 16'(k * 257), 1'b1);
            tick(7);
        end
        drain();
        checks++;
        if ({ovfl, drop_cnt} !== {1'b0, 16'd0}) begin
            failures++;
            $display("FAIL wrap_ovfl: ovfl=%b drop=%0d, required 0 0", ovfl, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        send(16'h2468, 16'h1357, 1'b1);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
`ifdef RX_READER_TSTAMP_EN
        ts_exp = 16'h0;
`endif
        checks++;
        if ({empty, count, rd_i, rd_q, dout} !== {1'b1, CW'(0), 2'b00, 16'h0}) begin
            failures++;
            $display("FAIL reset_mid: empty=%b count=%0d rd=%b%b dout=%h, required 1 0 00 0000", empty, count, rd_i, rd_q, dout);
        end
        send(16'hFEDC, 16'h0123, 1'b1);
        tick(W + 1);
        checks++;
        if (count !== CW'(W)) begin
            failures++;
            $display("FAIL post_reset_count: got %0d, required %0d", count, W);
        end
        drain();
    endtask

`ifdef RX_READER_TSTAMP_EN
    task automatic test_tstamp();
        do_reset();
        pop_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(16'h4000 + 16'(k), 16'h5000 + 16'(k), 1'b1);
            tick(7);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_clr_priority();
        test_wrap();
        test_reset_mid();
`ifdef RX_READER_TSTAMP_EN
        test_tstamp();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: %0d expected words never produced, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
